// File: rtl/seq_divider_8_if.sv
// rtl/seq_divider_8_if.sv - operand/result handshake bundle for seq_divider_8
interface seq_divider_8_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_8.sv
// rtl/seq_divider_8.sv - unsigned restoring divider, one quotient bit per cycle
module seq_divider_8 #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_8_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] d_reg;
  logic             dbz_reg;
  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   trial_a;
  logic [WIDTH+1:0] trial_sum;
  logic             borrow;
  logic             unused_trial_msb;

  assign accept    = bus.in_valid && (state == IDLE);
  assign last_step = (cnt == CW'(WIDTH - 1));

  // Full WIDTH+1 bit shifted remainder: r can exceed half the divisor range.
  assign trial_a          = {r_reg, q_reg[WIDTH-1]};
  assign trial_sum        = {1'b0, trial_a} + {1'b0, ~{1'b0, d_reg}} + (WIDTH+2)'(1);
  assign borrow           = ~trial_sum[WIDTH+1];
  assign unused_trial_msb = trial_sum[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (bus.divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      d_reg   <= '0;
      dbz_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            d_reg <= bus.divisor;
            cnt   <= '0;
            if (bus.divisor == '0) begin
              q_reg   <= '1;
              r_reg   <= bus.dividend;
              dbz_reg <= 1'b1;
            end else begin
              q_reg   <= bus.dividend;
              r_reg   <= '0;
              dbz_reg <= 1'b0;
            end
          end
        end
        CALC: begin
          q_reg <= {q_reg[WIDTH-2:0], ~borrow};
          r_reg <= borrow ? trial_a[WIDTH-1:0] : trial_sum[WIDTH-1:0];
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = q_reg;
  assign bus.remainder   = r_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_divider_8.sv
// tb/tb_seq_divider_8.sv - scoreboard bench for seq_divider_8 with directed vectors
module tb_seq_divider_8;
  localparam int W = 8;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
    int         acc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  vec_t vecs[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_divider_8_if #(.WIDTH(W)) bus();

  seq_divider_8 #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops on the first cycle of each result, then checks it every cycle it is held.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_cur = 1'b0;
      end else if (bus.out_valid) begin
        if (!have_cur) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out_valid actual=1 expected=0 (t=%0t)", $time);
          end else begin
            cur      = sb.pop_front();
            have_cur = 1'b1;
            check("latency", cyc - cur.acc, cur.lat);
          end
        end
        if (have_cur) begin
          check("quotient", bus.quotient, cur.q);
          check("remainder", bus.remainder, cur.r);
          check("div_by_zero", bus.div_by_zero, cur.z);
          if (bus.out_ready) have_cur = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                      input logic [7:0] er, input logic ez, input bit push, output int acc);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_accept expected=accept a=%0d b=%0d", a, b);
    end else if (push) begin
      sb.push_back('{q: eq, r: er, z: ez, lat: (b == 8'd0) ? 0 : W, acc: acc});
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !have_cur) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending expected=0_pending", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int consume;
    bit seen;

    vecs.push_back('{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,   z: 1'b0});
    vecs.push_back('{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   z: 1'b0});
    vecs.push_back('{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   z: 1'b0});
    vecs.push_back('{a: 8'd37,  b: 8'd0,   q: 8'd255, r: 8'd37,  z: 1'b1});
    vecs.push_back('{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,   z: 1'b0});
    vecs.push_back('{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   z: 1'b0});
    vecs.push_back('{a: 8'd250, b: 8'd251, q: 8'd0,   r: 8'd250, z: 1'b0});
    vecs.push_back('{a: 8'd255, b: 8'd128, q: 8'd1,   r: 8'd127, z: 1'b0});
    vecs.push_back('{a: 8'd129, b: 8'd2,   q: 8'd64,  r: 8'd1,   z: 1'b0});
    vecs.push_back('{a: 8'd0,   b: 8'd0,   q: 8'd255, r: 8'd0,   z: 1'b1});

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
    check("reset_div_by_zero", bus.div_by_zero, 0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, 1'b1, acc);
    end
    drain();

    // Result held under back-pressure while a second pair waits on in_valid.
    bus.out_ready = 1'b0;
    send(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 1'b1, acc);
    bus.in_valid = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 8'd4;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("hold_out_valid_seen", seen, 1);
    repeat (5) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    consume = cyc;
    send(8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 1'b1, acc);
    check("accept_first_idle_cycle", acc, consume + 1);
    drain();

    // Reset during the fourth CALC cycle discards the operation.
    send(8'd50, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0, acc);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    check("abort_div_by_zero", bus.div_by_zero, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort_no_out_valid", seen, 0);
    @(posedge clk);
    #1;
    send(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b1, acc);
    drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
